// File: rtl/axi_lite_mem_master.sv
// axi_lite_mem_master: turns one core memory request (valid/ready) into a single
// AXI-lite read or write and hands the read data / error status back on a
// valid/ready response channel. Exactly one transaction is in flight at a time.
`timescale 1ns/1ps
module axi_lite_mem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // core request / response
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                req_wen_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wmask_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  // AR channel
  output logic                mst_ar_valid_o,
  input  logic                mst_ar_ready_i,
  output logic [ADDR_W-1:0]   mst_ar_addr_o,
  // R channel
  input  logic                mst_r_valid_i,
  output logic                mst_r_ready_o,
  input  logic [DATA_W-1:0]   mst_r_data_i,
  input  logic [1:0]          mst_r_resp_i,
  // AW channel
  output logic                mst_aw_valid_o,
  input  logic                mst_aw_ready_i,
  output logic [ADDR_W-1:0]   mst_aw_addr_o,
  // W channel
  output logic                mst_w_valid_o,
  input  logic                mst_w_ready_i,
  output logic [DATA_W-1:0]   mst_w_data_o,
  output logic [DATA_W/8-1:0] mst_w_strb_o,
  // B channel
  input  logic                mst_b_valid_i,
  output logic                mst_b_ready_o,
  input  logic [1:0]          mst_b_resp_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    RD_ADDR = 6'b000010,
    RD_DATA = 6'b000100,
    WR_REQ  = 6'b001000,
    WR_RESP = 6'b010000,
    RSP     = 6'b100000
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wmask_reg;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg, w_done_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic                aw_hs, w_hs;

  // AXI address/data come only from the request latch, so they stay stable while valid
  assign mst_ar_addr_o = addr_reg;
  assign mst_aw_addr_o = addr_reg;
  assign mst_w_data_o  = wdata_reg;
  assign mst_w_strb_o  = wmask_reg;
  assign rsp_rdata_o   = rdata_reg;
  assign rsp_err_o     = err_reg;

  // Handshakes this cycle; AW/W valids are exactly "in WR_REQ and not yet done"
  assign aw_hs = (state_reg == WR_REQ) && !aw_done_reg && mst_aw_ready_i;
  assign w_hs  = (state_reg == WR_REQ) && !w_done_reg && mst_w_ready_i;

  // State, completion flags, response registers and request latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wmask_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      if ((state_reg == IDLE) && req_valid_i) begin
        addr_reg  <= req_addr_i;
        wdata_reg <= req_wdata_i;
        wmask_reg <= req_wmask_i;
      end
    end
  end

  // Next-state logic and state-decoded channel controls
  always_comb begin
    state_next     = state_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    mst_b_ready_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = req_wen_i ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        mst_ar_valid_o = 1'b1;
        if (mst_ar_ready_i) state_next = RD_DATA;
      end
      RD_DATA: begin
        mst_r_ready_o = 1'b1;
        if (mst_r_valid_i) begin
          rdata_next = mst_r_data_i;
          err_next   = |mst_r_resp_i;
          state_next = RSP;
        end
      end
      WR_REQ: begin
        mst_aw_valid_o = !aw_done_reg;
        mst_w_valid_o  = !w_done_reg;
        // Leave as soon as both halves are accepted, counting this cycle's handshakes
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = WR_RESP;
        end else begin
          aw_done_next = aw_done_reg || aw_hs;
          w_done_next  = w_done_reg || w_hs;
        end
      end
      WR_RESP: begin
        mst_b_ready_o = 1'b1;
        if (mst_b_valid_i) begin
          rdata_next = '0;
          err_next   = |mst_b_resp_i;
          state_next = RSP;
        end
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Bench for axi_lite_mem_master: directed requests against a configurable-wait
// AXI-lite slave model; expected responses are queued at request acceptance and
// checked by an independent response monitor.
`timescale 1ns/1ps
module tb_axi_lite_mem_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_wen_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wmask_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready;
  logic        w_valid, w_ready, b_valid, b_ready;
  logic [31:0] ar_addr, aw_addr, r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic [3:0]  w_strb;

  axi_lite_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .mst_ar_valid_o(ar_valid), .mst_ar_ready_i(ar_ready), .mst_ar_addr_o(ar_addr),
    .mst_r_valid_i(r_valid), .mst_r_ready_o(r_ready), .mst_r_data_i(r_data), .mst_r_resp_i(r_resp),
    .mst_aw_valid_o(aw_valid), .mst_aw_ready_i(aw_ready), .mst_aw_addr_o(aw_addr),
    .mst_w_valid_o(w_valid), .mst_w_ready_i(w_ready), .mst_w_data_o(w_data), .mst_w_strb_o(w_strb),
    .mst_b_valid_i(b_valid), .mst_b_ready_o(b_ready), .mst_b_resp_i(b_resp)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;   // 0 = latency not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   negcyc = 0;

  // slave configuration and expectations for the current vector
  int          cfg_ar_wait, cfg_r_wait, cfg_aw_wait, cfg_w_wait, cfg_b_wait;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_rresp, cfg_bresp;
  logic [31:0] exp_araddr, exp_awaddr, exp_wdata;
  logic [3:0]  exp_wstrb;
  int          ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, wreq_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Slave model: decides its readies/valids at the falling edge, so every
  // handshake it counts completes on the following rising edge.
  initial begin
    int  ar_w, r_w, aw_w, w_w, b_w;
    bit  rd_pend, aw_got, w_got;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    rd_pend = 0; aw_got = 0; w_got = 0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        rd_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        if (rd_pend) begin
          if (r_w >= cfg_r_wait) begin
            r_valid = 1; r_data = cfg_rdata; r_resp = cfg_rresp;
            if (r_ready) rd_pend = 0;
          end else begin
            r_valid = 0; r_w++;
          end
        end else r_valid = 0;
        if (ar_valid) begin
          if (ar_w >= cfg_ar_wait) begin
            ar_ready = 1; ar_hs_n++; ar_w = 0; rd_pend = 1; r_w = 0;
            chk("ar_addr", ar_addr, exp_araddr);
          end else begin
            ar_ready = 0; ar_w++;
          end
        end else begin
          ar_ready = 0; ar_w = 0;
        end
        if (aw_got && w_got) begin
          if (b_w >= cfg_b_wait) begin
            b_valid = 1; b_resp = cfg_bresp;
            if (b_ready) begin aw_got = 0; w_got = 0; b_hs_n++; b_w = 0; end
          end else begin
            b_valid = 0; b_w++;
          end
        end else b_valid = 0;
        if (aw_valid || w_valid) wreq_cyc++;
        if (aw_valid) begin
          if (aw_w >= cfg_aw_wait) begin
            aw_ready = 1; aw_hs_n++; aw_w = 0; aw_got = 1;
            chk("aw_addr", aw_addr, exp_awaddr);
          end else begin
            aw_ready = 0; aw_w++;
          end
        end else begin
          aw_ready = 0; aw_w = 0;
        end
        if (w_valid) begin
          if (w_w >= cfg_w_wait) begin
            w_ready = 1; w_hs_n++; w_w = 0; w_got = 1;
            chk("w_data", w_data, exp_wdata);
            chk("w_strb", w_strb, exp_wstrb);
          end else begin
            w_ready = 0; w_w++;
          end
        end else begin
          w_ready = 0; w_w = 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each response handshake and
  // checks hold-stability, latency and single-outstanding behaviour.
  initial begin
    bit outstanding;
    bit first_seen;
    int acc_cyc;
    outstanding = 0; first_seen = 0; acc_cyc = 0;
    forever begin
      @(negedge clk_i);
      negcyc++;
      if (rst_i) begin
        outstanding = 0; first_seen = 0;
      end else begin
        if (rsp_valid_o) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b with nothing expected", rsp_rdata_o, rsp_err_o);
          end else begin
            if (!first_seen) begin
              first_seen = 1;
              if (exp_q[0].lat != 0) chk("rsp_latency", negcyc - acc_cyc, exp_q[0].lat);
            end
            if (rsp_ready_i) begin
              $display("rsp: rdata 0x%08h err %0b (expected 0x%08h err %0b)",
                       rsp_rdata_o, rsp_err_o, exp_q[0].rdata, exp_q[0].err);
              chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
              chk("rsp_err", rsp_err_o, exp_q[0].err);
              void'(exp_q.pop_front());
              first_seen = 0;
              outstanding = 0;
            end else begin
              chk("hold_rdata", rsp_rdata_o, exp_q[0].rdata);
              chk("hold_err", rsp_err_o, exp_q[0].err);
              chk("hold_req_ready", req_ready_o, 0);
              chk("hold_axi_valid", {ar_valid, aw_valid, w_valid}, 0);
            end
          end
        end
        if (req_valid_i && req_ready_o) begin
          chk("accept_when_idle", outstanding, 0);
          outstanding = 1;
          acc_cyc = negcyc;
        end
      end
    end
  end

  // Issue one request (caller sits just after a rising edge); queue its expected response
  task automatic issue(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic [31:0] erd, input logic eerr,
                       input int lat, input bit push);
    exp_t e;
    req_addr_i = addr; req_wen_i = wen; req_wdata_i = wdata; req_wmask_i = wmask;
    req_valid_i = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (req_ready_o) break;
    end
    if (!req_ready_o) begin
      n_vec++; n_err++;
      $display("FAIL req_accept_timeout: req_ready_o got 0 required 1 addr 0x%08h", addr);
    end
    $display("req: addr 0x%08h wen %0b wdata 0x%08h mask %b", addr, wen, wdata, wmask);
    if (push) begin
      e.rdata = erd; e.err = eerr; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk_i); #1;
    req_valid_i = 0;
  endtask

  // Wait (bounded) for every queued response to be consumed
  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk_i);
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL rsp_timeout: %0d responses pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i); #1;
  endtask

  task automatic check_counts(input int ar, input int aw, input int w, input int b, input int wc);
    chk("ar_hs_count", ar_hs_n, ar);
    chk("aw_hs_count", aw_hs_n, aw);
    chk("w_hs_count", w_hs_n, w);
    chk("b_hs_count", b_hs_n, b);
    chk("wr_req_cycles", wreq_cyc, wc);
    ar_hs_n = 0; aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; wreq_cyc = 0;
  endtask

  task automatic cfg(input int arw, input int rw, input logic [31:0] rd, input logic [1:0] rr,
                     input int aww, input int ww, input int bw, input logic [1:0] br);
    cfg_ar_wait = arw; cfg_r_wait = rw; cfg_rdata = rd; cfg_rresp = rr;
    cfg_aw_wait = aww; cfg_w_wait = ww; cfg_b_wait = bw; cfg_bresp = br;
  endtask

  initial begin
    rst_i = 1; req_valid_i = 0; req_addr_i = '0; req_wen_i = 0; req_wdata_i = '0;
    req_wmask_i = '0; rsp_ready_i = 1;
    cfg(0, 0, 32'h0, 2'b00, 0, 0, 0, 2'b00);
    exp_araddr = '0; exp_awaddr = '0; exp_wdata = '0; exp_wstrb = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_valids", {ar_valid, aw_valid, w_valid, rsp_valid_o}, 0);
    chk("rst_readies", {r_ready, b_ready}, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_err", rsp_err_o, 0);
    @(posedge clk_i); #1;
    rst_i = 0;

    // read with a 7-cycle data wait
    cfg(0, 7, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 2'b00);
    exp_araddr = 32'h8000_0000;
    issue(32'h8000_0000, 0, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 1);
    wait_done();
    check_counts(1, 0, 0, 0, 0);

    // zero-wait read: minimum latency
    cfg(0, 0, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 2'b00);
    exp_araddr = 32'h8000_0004;
    issue(32'h8000_0004, 0, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 3, 1);
    wait_done();
    check_counts(1, 0, 0, 0, 0);

    // write, AW accepted 2 cycles before W
    cfg(0, 0, 32'h0, 2'b00, 0, 2, 1, 2'b00);
    exp_awaddr = 32'h8000_0010; exp_wdata = 32'h1234_5678; exp_wstrb = 4'b0011;
    issue(32'h8000_0010, 1, 32'h1234_5678, 4'b0011, 32'h0, 0, 0, 1);
    wait_done();
    check_counts(0, 1, 1, 1, 3);

    // write, AW and W together, SLVERR on B
    cfg(0, 0, 32'h0, 2'b00, 0, 0, 0, 2'b10);
    exp_awaddr = 32'h8000_0020; exp_wdata = 32'hCAFE_F00D; exp_wstrb = 4'b1111;
    issue(32'h8000_0020, 1, 32'hCAFE_F00D, 4'b1111, 32'h0, 1, 3, 1);
    wait_done();
    check_counts(0, 1, 1, 1, 1);

    // read with DECERR: data passed through, error flagged
    cfg(2, 1, 32'h5555_AAAA, 2'b11, 0, 0, 0, 2'b00);
    exp_araddr = 32'h8000_0024;
    issue(32'h8000_0024, 0, 32'h0, 4'h0, 32'h5555_AAAA, 1, 0, 1);
    wait_done();
    check_counts(1, 0, 0, 0, 0);

    // response back-pressure: hold rsp_ready_i low
    cfg(0, 0, 32'h0F0F_1234, 2'b00, 0, 0, 0, 2'b00);
    exp_araddr = 32'h8000_0030;
    rsp_ready_i = 0;
    issue(32'h8000_0030, 0, 32'h0, 4'h0, 32'h0F0F_1234, 0, 3, 1);
    repeat (7) @(posedge clk_i);
    #1 rsp_ready_i = 1;
    wait_done();
    check_counts(1, 0, 0, 0, 0);

    // back-to-back read then write with the request held valid
    cfg(0, 0, 32'h1111_2222, 2'b00, 1, 1, 0, 2'b00);
    exp_araddr = 32'h8000_0040;
    exp_awaddr = 32'h8000_0044; exp_wdata = 32'h3333_4444; exp_wstrb = 4'b1100;
    issue(32'h8000_0040, 0, 32'h0, 4'h0, 32'h1111_2222, 0, 3, 1);
    issue(32'h8000_0044, 1, 32'h3333_4444, 4'b1100, 32'h0, 0, 0, 1);
    wait_done();
    check_counts(1, 1, 1, 1, 2);

    // reset while waiting for read data
    cfg(0, 20, 32'h9999_9999, 2'b00, 0, 0, 0, 2'b00);
    exp_araddr = 32'h8000_0050;
    issue(32'h8000_0050, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (r_ready) break;
    end
    chk("reach_rd_data", r_ready, 1);
    @(posedge clk_i); #1;
    rst_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("abort_valids", {ar_valid, aw_valid, w_valid, rsp_valid_o}, 0);
    chk("abort_readies", {r_ready, b_ready}, 0);
    chk("abort_req_ready", req_ready_o, 1);
    @(posedge clk_i); #1;
    rst_i = 0;
    check_counts(1, 0, 0, 0, 0);

    // recovery read after the abort
    cfg(0, 0, 32'h7777_8888, 2'b00, 0, 0, 0, 2'b00);
    exp_araddr = 32'h8000_0060;
    issue(32'h8000_0060, 0, 32'h0, 4'h0, 32'h7777_8888, 0, 3, 1);
    wait_done();
    check_counts(1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
